axil_write_bridge: RTL

AXI4-Lite write bridge sitting directly downstream of the request master. It consumes the master's flat request (address, data, valid), decodes the address against the two mapped slave addresses, and runs the full AXI4-Lite write handshake (AW, W, B) on a single downstream port with a slave-select output. It then returns the 2-bit write response to the master's `resp_in`.

---
 rtl/axil_write_bridge.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axil_write_bridge.sv
// axil_write_bridge: turns a flat master write request into an AXI4-Lite AW/W/B transaction to one of two slaves.
// Define AXIL_BRIDGE_TIMEOUT_EN to add a watchdog that aborts stalled transfers with SLVERR.
module axil_write_bridge #(
  parameter logic [31:0] ADDR1 = 32'h00110022,
  parameter logic [31:0] ADDR2 = 32'h11111111
`ifdef AXIL_BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        req_ready,
  output logic [1:0]  resp_out,
  output logic        resp_valid,
  output logic        slave_sel,
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  // The response phase is the registered resp_valid pulse; the FSM is already
  // back in IDLE during that cycle, so the next request is taken at its end.
  typedef enum logic [1:0] {IDLE, ADDR_DATA, WAIT_B} state_t;

  state_t state_reg;
  logic   addr_hit;
  logic   aw_done;
  logic   w_done;

  assign req_ready = (state_reg == IDLE) & ~ARESET;
  assign addr_hit  = (addr_in == ADDR1) || (addr_in == ADDR2);
  assign aw_done   = ~AWVALID | AWREADY;
  assign w_done    = ~WVALID | WREADY;

`ifdef AXIL_BRIDGE_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  logic [TIMER_W-1:0] timer_reg;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg  <= IDLE;
      AWADDR     <= '0;
      WDATA      <= '0;
      WSTRB      <= '0;
      AWVALID    <= 1'b0;
      WVALID     <= 1'b0;
      BREADY     <= 1'b0;
      slave_sel  <= 1'b0;
      resp_out   <= 2'b00;
      resp_valid <= 1'b0;
`ifdef AXIL_BRIDGE_TIMEOUT_EN
      timer_reg  <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
`ifdef AXIL_BRIDGE_TIMEOUT_EN
      if (state_reg != IDLE) timer_reg <= timer_reg + 1'b1;
`endif
      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            if (addr_hit) begin
              AWADDR    <= addr_in;
              WDATA     <= data_in;
              WSTRB     <= 4'hF;
              slave_sel <= (addr_in == ADDR2);
              AWVALID   <= 1'b1;
              WVALID    <= 1'b1;
              state_reg <= ADDR_DATA;
`ifdef AXIL_BRIDGE_TIMEOUT_EN
              timer_reg <= '0;
`endif
            end else begin
              // Unmapped address: answer DECERR without touching the bus.
              resp_out   <= 2'b11;
              resp_valid <= 1'b1;
            end
          end
        end
        ADDR_DATA: begin
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            BREADY    <= 1'b1;
            state_reg <= WAIT_B;
          end
`ifdef AXIL_BRIDGE_TIMEOUT_EN
          else if (timer_reg >= TIMER_LAST) begin
            AWVALID    <= 1'b0;
            WVALID     <= 1'b0;
            resp_out   <= 2'b10;
            resp_valid <= 1'b1;
            state_reg  <= IDLE;
          end
`endif
        end
        WAIT_B: begin
          if (BVALID && BREADY) begin
            BREADY     <= 1'b0;
            resp_out   <= BRESP;
            resp_valid <= 1'b1;
            state_reg  <= IDLE;
          end
`ifdef AXIL_BRIDGE_TIMEOUT_EN
          else if (timer_reg >= TIMER_LAST) begin
            BREADY     <= 1'b0;
            resp_out   <= 2'b10;
            resp_valid <= 1'b1;
            state_reg  <= IDLE;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
